// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns / InvMixColumns engine for one 128-bit state
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_flush      synchronous abort back to IDLE
//   i_in_valid   i_in_data/i_in_mode valid
//   o_in_ready   block accepts a new state (IDLE)
//   i_in_data    state, row-major: s(r,c) = data[127-8*(4r+c) -: 8]
//   i_in_mode    0 = MixColumns, 1 = InvMixColumns
//   o_out_valid  o_out_data holds a finished state (DONE)
//   i_out_ready  consumer accepts o_out_data
//   o_out_data   result, same byte layout as i_in_data
module mix_columns_iter #(
    parameter int COLS_PER_BEAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [127:0] i_in_data,
    input  logic         i_in_mode,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [127:0] o_out_data
);
    localparam int NBEATS = 4 / COLS_PER_BEAT;
    localparam int KW = NBEATS > 1 ? $clog2(NBEATS) : 1;
    localparam int SH = 32 * COLS_PER_BEAT;

    if (COLS_PER_BEAT != 1 && COLS_PER_BEAT != 2 && COLS_PER_BEAT != 4) begin : g_bad_cpb
        $error("COLS_PER_BEAT must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state, w_next;
    logic [KW-1:0]   r_k;
    logic            r_mode;
    logic [127:0]    r_cols, r_res, w_in_cm;
    logic [SH-1:0]   w_new;
    logic            w_accept, w_last;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row 0 of the column product; the inverse shares xtime chains across
    // terms by linearity: 0e/0b/0d/09 all carry an x8 term, x4 only on a0/a2,
    // x2 only on a0/a1.
    function automatic logic [7:0] row(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] a2, input logic [7:0] a3,
                                       input logic inv);
        logic [7:0] f, i;
        f = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        i = xt(xt(xt(a0 ^ a1 ^ a2 ^ a3))) ^ xt(xt(a0 ^ a2)) ^ xt(a0 ^ a1) ^ a1 ^ a2 ^ a3;
        return inv ? i : f;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] a, input logic inv);
        return {row(a[31:24], a[23:16], a[15:8], a[7:0], inv),
                row(a[23:16], a[15:8], a[7:0], a[31:24], inv),
                row(a[15:8], a[7:0], a[31:24], a[23:16], inv),
                row(a[7:0], a[31:24], a[23:16], a[15:8], inv)};
    endfunction

    // Work registers are column-major so each beat consumes the top columns of
    // r_cols and shifts results into the bottom of r_res: no column muxing.
    for (genvar r = 0; r < 4; r++) begin : g_r
        for (genvar c = 0; c < 4; c++) begin : g_c
            assign w_in_cm[127-32*c-8*r -: 8]    = i_in_data[127-32*r-8*c -: 8];
            assign o_out_data[127-32*r-8*c -: 8] = r_res[127-32*c-8*r -: 8];
        end
    end

    for (genvar j = 0; j < COLS_PER_BEAT; j++) begin : g_col
        assign w_new[32*(COLS_PER_BEAT-1-j) +: 32] = mix(r_cols[127-32*j -: 32], r_mode);
    end

    assign w_accept    = r_state == IDLE && i_in_valid;
    assign w_last      = r_k == KW'(NBEATS - 1);
    assign o_in_ready  = r_state == IDLE;
    assign o_out_valid = r_state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = i_flush ? IDLE :
                 r_state == IDLE ? (i_in_valid ? BUSY : IDLE) :
                 r_state == BUSY ? (w_last ? DONE : BUSY) :
                 (i_out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || i_flush) begin
            r_k    <= '0;
            r_mode <= 1'b0;
            r_cols <= '0;
            r_res  <= '0;
        end else if (w_accept) begin
            r_k    <= '0;
            r_mode <= i_in_mode;
            r_cols <= w_in_cm;
        end else if (r_state == BUSY) begin
            r_k    <= r_k + 1'b1;
            r_cols <= r_cols << SH;
            r_res  <= (r_res << SH) | 128'(w_new);
        end
    end
endmodule
